// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
//   Shared definitions for the element-wise matrix unit:
//     mode_e   - operation encodings (scalar mul, add, sub, Hadamard)
//     state_e  - control FSM states
//     dim_w    - width needed to hold a dimension value 0..max_dim
//     ceil_div - integer ceiling division used for the beat count
// -----------------------------------------------------------------------------
package matrix_pkg;

  typedef enum logic [1:0] {
    MODE_SMUL = 2'b00,  // A * scalar
    MODE_ADD  = 2'b01,  // A + B
    MODE_SUB  = 2'b10,  // A - B
    MODE_HAD  = 2'b11   // A .* B
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Bits needed to represent every dimension value 0..max_dim inclusive.
  function automatic int dim_w(input int max_dim);
    return $clog2(max_dim + 1);
  endfunction

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/matrix_elem_alu.sv
// -----------------------------------------------------------------------------
// matrix_elem_alu
//   One combinational lane of the element-wise matrix unit.
//   Ports:
//     mode        - operation select (mode_e)
//     a           - element of A
//     b_or_scalar - element of B, or the latched scalar in MODE_SMUL
//     result      - wrapped (SATURATE=0) or clamped (SATURATE=1) result
//   Multiplies keep the full 2*DATA_WIDTH product and add keeps the carry,
//   so the clamp decision sees the true overflow; subtract clamps to 0 on
//   borrow.
// -----------------------------------------------------------------------------
module matrix_elem_alu
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int SATURATE   = 0
) (
  input  mode_e                 mode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b_or_scalar,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [DATA_WIDTH-1:0] MAX_VAL = '1;
  localparam bit                    SAT     = (SATURATE != 0);

  logic [2*DATA_WIDTH-1:0] product;
  logic [DATA_WIDTH:0]     sum;
  logic [DATA_WIDTH:0]     diff;

  assign product = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b_or_scalar};
  assign sum     = {1'b0, a} + {1'b0, b_or_scalar};
  // Top bit of diff is the borrow out of the unsigned subtraction.
  assign diff    = {1'b0, a} - {1'b0, b_or_scalar};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    result = '0;
    case (mode)
      MODE_SMUL,
      MODE_HAD: result = (SAT && (|product[2*DATA_WIDTH-1:DATA_WIDTH]))
                         ? MAX_VAL : product[DATA_WIDTH-1:0];
      MODE_ADD: result = (SAT && sum[DATA_WIDTH]) ? MAX_VAL : sum[DATA_WIDTH-1:0];
      MODE_SUB: result = (SAT && diff[DATA_WIDTH]) ? '0 : diff[DATA_WIDTH-1:0];
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/matrix_elementwise.sv
// -----------------------------------------------------------------------------
// matrix_elementwise
//   Element-wise matrix unit (scalar mul, add, sub, Hadamard) on a row-major
//   MAX_DIM x MAX_DIM matrix with fixed stride MAX_DIM. LANES elements are
//   produced per beat; a full matrix takes ceil(MAX_DIM^2 / LANES) beats.
//   Ports:
//     clk, reset_n       - clock, asynchronous active-low reset
//     start              - request, accepted only in IDLE
//     abort              - cancel while running (clears result outputs)
//     mode               - 00 A*scalar, 01 A+B, 10 A-B, 11 A.*B
//     r, c / r_b, c_b    - dimensions of A / B (B ignored for scalar mul)
//     scalar             - scalar operand, latched on accept
//     mat_a, mat_b       - operands, element k at [k*DATA_WIDTH +: DATA_WIDTH];
//                          not latched, must stay stable while busy
//     busy               - computation in progress
//     done               - one-cycle completion pulse (also on rejection)
//     error              - last request was rejected
//     r_out, c_out       - dimensions of the result
//     mat_out            - result matrix; elements outside r_out x c_out are 0
// -----------------------------------------------------------------------------
module matrix_elementwise
  import matrix_pkg::*;
#(
  parameter  int DATA_WIDTH = 9,
  parameter  int MAX_DIM    = 5,
  parameter  int LANES      = 5,
  parameter  int SATURATE   = 0,
  localparam int DIM_W      = dim_w(MAX_DIM),
  localparam int N_ELEM     = MAX_DIM * MAX_DIM,
  localparam int MAT_W      = N_ELEM * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [DIM_W-1:0]      r,
  input  logic [DIM_W-1:0]      c,
  input  logic [DIM_W-1:0]      r_b,
  input  logic [DIM_W-1:0]      c_b,
  input  logic [DATA_WIDTH-1:0] scalar,
  input  logic [MAT_W-1:0]      mat_a,
  input  logic [MAT_W-1:0]      mat_b,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DIM_W-1:0]      r_out,
  output logic [DIM_W-1:0]      c_out,
  output logic [MAT_W-1:0]      mat_out
);

  localparam int NB     = ceil_div(N_ELEM, LANES);
  // The last beat may be partial; operand views are padded to a whole
  // number of beats so the lane muxes never index past the matrix.
  localparam int PAD    = NB * LANES;
  localparam int BEAT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);

  state_e                state;
  logic [BEAT_W-1:0]     beat;
  mode_e                 mode_q;
  logic [DATA_WIDTH-1:0] scalar_q;

  logic [DATA_WIDTH-1:0] a_elem   [PAD];
  logic [DATA_WIDTH-1:0] b_elem   [PAD];
  logic [DATA_WIDTH-1:0] lane_a   [LANES];
  logic [DATA_WIDTH-1:0] lane_b   [LANES];
  logic [DATA_WIDTH-1:0] lane_res [LANES];
  logic                  wr_en    [N_ELEM];
  logic [DATA_WIDTH-1:0] wr_val   [N_ELEM];

  logic dims_bad;
  logic shape_bad;
  logic req_bad;

  // ---------------------------------------------------------------------------
  // Request validation: A must fit the array; B must match A except for
  // scalar multiply, which has no second matrix.
  // ---------------------------------------------------------------------------
  assign dims_bad  = (r == '0) || (r > DIM_W'(MAX_DIM)) ||
                     (c == '0) || (c > DIM_W'(MAX_DIM));
  assign shape_bad = (mode != MODE_SMUL) && ((r_b != r) || (c_b != c));
  assign req_bad   = dims_bad || shape_bad;

  // ---------------------------------------------------------------------------
  // Element views of the flat operand buses, zero-padded to PAD entries.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < PAD; k++) begin : g_pad
    if (k < N_ELEM) begin : g_real
      assign a_elem[k] = mat_a[k*DATA_WIDTH +: DATA_WIDTH];
      assign b_elem[k] = mat_b[k*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_fill
      assign a_elem[k] = '0;
      assign b_elem[k] = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Lane operand select: lane l of beat j works on element j*LANES + l.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_a[l] = '0;
      lane_b[l] = '0;
      for (int j = 0; j < NB; j++) begin
        if (beat == BEAT_W'(j)) begin
          lane_a[l] = a_elem[j*LANES + l];
          lane_b[l] = b_elem[j*LANES + l];
        end
      end
      if (mode_q == MODE_SMUL) begin
        lane_b[l] = scalar_q;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    matrix_elem_alu #(
      .DATA_WIDTH (DATA_WIDTH),
      .SATURATE   (SATURATE)
    ) u_alu (
      .mode        (mode_q),
      .a           (lane_a[l]),
      .b_or_scalar (lane_b[l]),
      .result      (lane_res[l])
    );
  end

  // ---------------------------------------------------------------------------
  // Per-element write enable and value for the current beat. Element k is
  // owned by beat k/LANES, lane k%LANES; elements outside the r_out x c_out
  // window are written as zero so stale data never leaks into the result.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < N_ELEM; k++) begin : g_elem
    logic in_window;
    assign in_window = (DIM_W'(k / MAX_DIM) < r_out) &&
                       (DIM_W'(k % MAX_DIM) < c_out);
    assign wr_en[k]  = (beat == BEAT_W'(k / LANES));
    assign wr_val[k] = in_window ? lane_res[k % LANES] : '0;
  end

  // ---------------------------------------------------------------------------
  // Control FSM and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      beat     <= '0;
      mode_q   <= MODE_SMUL;
      scalar_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      r_out    <= '0;
      c_out    <= '0;
      // NOTE: the result bank is an output that must read 0 out of reset,
      // so it is reset as a whole rather than left uninitialised like RAM.
      mat_out  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (req_bad) begin
              // Rejected: outputs keep their previous result.
              error <= 1'b1;
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              mode_q   <= mode_e'(mode);
              scalar_q <= scalar;
              r_out    <= r;
              c_out    <= c;
              error    <= 1'b0;
              busy     <= 1'b1;
              beat     <= '0;
              state    <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          if (abort) begin
            // Abort takes priority over the final beat.
            busy    <= 1'b0;
            beat    <= '0;
            r_out   <= '0;
            c_out   <= '0;
            mat_out <= '0;
            state   <= ST_IDLE;
          end else begin
            for (int k = 0; k < N_ELEM; k++) begin
              if (wr_en[k]) begin
                mat_out[k*DATA_WIDTH +: DATA_WIDTH] <= wr_val[k];
              end
            end
            if (beat == LAST_BEAT) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end

        ST_FIN: begin
          // done drops via the default above; start is not sampled here.
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_elementwise.sv
// -----------------------------------------------------------------------------
// tb_matrix_elementwise
//   Three instances share operand inputs and have separate start lines:
//     dut 0: LANES=5, SATURATE=0 (defaults, 5 beats)
//     dut 1: LANES=4, SATURATE=1 (7 beats)
//     dut 2: LANES=1, SATURATE=0 (25 beats)
//   Expected results come from a behavioural model and are queued when a
//   request is issued, then popped and compared when the DUT signals done.
// -----------------------------------------------------------------------------
module tb_matrix_elementwise;
  import matrix_pkg::*;

  localparam int DW    = 9;
  localparam int MD    = 5;
  localparam int N     = MD * MD;
  localparam int MW    = N * DW;
  localparam int DIM_W = 3;
  localparam int ND    = 3;
  localparam int MAXV  = (1 << DW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             abort;
  logic [ND-1:0]    start_v;
  logic [1:0]       mode;
  logic [DIM_W-1:0] r, c, r_b, c_b;
  logic [DW-1:0]    scalar;
  logic [MW-1:0]    mat_a, mat_b;

  logic             busy_v    [ND];
  logic             done_v    [ND];
  logic             error_v   [ND];
  logic [DIM_W-1:0] r_out_v   [ND];
  logic [DIM_W-1:0] c_out_v   [ND];
  logic [MW-1:0]    mat_out_v [ND];

  matrix_elementwise #(.DATA_WIDTH(DW), .MAX_DIM(MD), .LANES(5), .SATURATE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .abort(abort), .mode(mode),
    .r(r), .c(c), .r_b(r_b), .c_b(c_b), .scalar(scalar), .mat_a(mat_a), .mat_b(mat_b),
    .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0]),
    .r_out(r_out_v[0]), .c_out(c_out_v[0]), .mat_out(mat_out_v[0]));

  matrix_elementwise #(.DATA_WIDTH(DW), .MAX_DIM(MD), .LANES(4), .SATURATE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .abort(abort), .mode(mode),
    .r(r), .c(c), .r_b(r_b), .c_b(c_b), .scalar(scalar), .mat_a(mat_a), .mat_b(mat_b),
    .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1]),
    .r_out(r_out_v[1]), .c_out(c_out_v[1]), .mat_out(mat_out_v[1]));

  matrix_elementwise #(.DATA_WIDTH(DW), .MAX_DIM(MD), .LANES(1), .SATURATE(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .abort(abort), .mode(mode),
    .r(r), .c(c), .r_b(r_b), .c_b(c_b), .scalar(scalar), .mat_a(mat_a), .mat_b(mat_b),
    .busy(busy_v[2]), .done(done_v[2]), .error(error_v[2]),
    .r_out(r_out_v[2]), .c_out(c_out_v[2]), .mat_out(mat_out_v[2]));

  typedef struct {
    int            dut;
    string         tag;
    logic [MW-1:0] mat;
    int            r_exp;
    int            c_exp;
    int            err;
    int            busy_cycles;
    int            done_cycle;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  int            nb_of  [ND] = '{5, 7, 25};
  int            sat_of [ND] = '{0, 1, 0};
  logic [MW-1:0] last_mat [ND];
  int            last_r   [ND];
  int            last_c   [ND];

  logic [DW-1:0] a_arr [N];
  logic [DW-1:0] b_arr [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic int elem_model(input int m, input int a, input int b, input int s);
    int v;
    case (m)
      1:       v = a + b;
      2:       v = a - b;
      default: v = a * b;
    endcase
    if (s != 0) begin
      if (v > MAXV) v = MAXV;
      if (v < 0)    v = 0;
    end else begin
      v = v & MAXV;
    end
    return v;
  endfunction

  function automatic logic [MW-1:0] mat_model(input int m, input int sc, input int rr,
                                              input int cc, input int s);
    logic [MW-1:0] res = '0;
    int v;
    for (int k = 0; k < N; k++) begin
      if ((k / MD) < rr && (k % MD) < cc) begin
        v = elem_model(m, int'(a_arr[k]), (m == 0) ? sc : int'(b_arr[k]), s);
        res[k*DW +: DW] = DW'(v);
      end
    end
    return res;
  endfunction

  task automatic load_inputs(input int m, input int sc, input int rr, input int cc,
                             input int rbb, input int cbb);
    mode   = 2'(m);
    scalar = DW'(sc);
    r      = DIM_W'(rr);
    c      = DIM_W'(cc);
    r_b    = DIM_W'(rbb);
    c_b    = DIM_W'(cbb);
    for (int k = 0; k < N; k++) begin
      mat_a[k*DW +: DW] = a_arr[k];
      mat_b[k*DW +: DW] = b_arr[k];
    end
  endtask

  // Drive a request, queue its expected outcome, pulse start for one edge.
  task automatic issue(input int d, input string tag, input int m, input int sc,
                       input int rr, input int cc, input int rbb, input int cbb);
    exp_t e;
    bit   ok;
    load_inputs(m, sc, rr, cc, rbb, cbb);
    ok = (rr >= 1) && (rr <= MD) && (cc >= 1) && (cc <= MD) &&
         ((m == 0) || ((rbb == rr) && (cbb == cc)));
    e.dut = d;
    e.tag = tag;
    if (ok) begin
      e.mat         = mat_model(m, sc, rr, cc, sat_of[d]);
      e.r_exp       = rr;
      e.c_exp       = cc;
      e.err         = 0;
      e.busy_cycles = nb_of[d];
      e.done_cycle  = nb_of[d] + 1;
      last_mat[d]   = e.mat;
      last_r[d]     = rr;
      last_c[d]     = cc;
    end else begin
      e.mat         = last_mat[d];
      e.r_exp       = last_r[d];
      e.c_exp       = last_c[d];
      e.err         = 1;
      e.busy_cycles = 0;
      e.done_cycle  = 1;
    end
    sb.push_back(e);
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
  endtask

  // Wait (bounded) for done on the DUT of the oldest queued request and
  // compare timing and results. Cycle 1 is the cycle after the start edge.
  task automatic collect(input int budget);
    exp_t e;
    int   d;
    int   busy_cnt = 0;
    int   done_cyc = 0;
    e = sb.pop_front();
    d = e.dut;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (busy_v[d]) busy_cnt++;
      if (done_v[d]) begin
        done_cyc = cyc;
        break;
      end
      tick();
    end
    check({e.tag, "_done_cycle"},  MW'(done_cyc),      MW'(e.done_cycle));
    check({e.tag, "_busy_cycles"}, MW'(busy_cnt),      MW'(e.busy_cycles));
    check({e.tag, "_mat_out"},     mat_out_v[d],       e.mat);
    check({e.tag, "_r_out"},       MW'(r_out_v[d]),    MW'(e.r_exp));
    check({e.tag, "_c_out"},       MW'(c_out_v[d]),    MW'(e.c_exp));
    check({e.tag, "_error"},       MW'(error_v[d]),    MW'(e.err));
    tick();
    check({e.tag, "_done_single"}, MW'(done_v[d]),     '0);
    check({e.tag, "_busy_after"},  MW'(busy_v[d]),     '0);
  endtask

  task automatic check_zero_outputs(input int d, input string tag);
    check({tag, "_busy"},    MW'(busy_v[d]),  '0);
    check({tag, "_done"},    MW'(done_v[d]),  '0);
    check({tag, "_error"},   MW'(error_v[d]), '0);
    check({tag, "_r_out"},   MW'(r_out_v[d]), '0);
    check({tag, "_c_out"},   MW'(c_out_v[d]), '0);
    check({tag, "_mat_out"}, mat_out_v[d],    '0);
  endtask

  initial begin
    int dones;
    logic [DW-1:0] e0;

    reset_n = 1'b0;
    abort   = 1'b0;
    start_v = '0;
    for (int k = 0; k < N; k++) begin
      a_arr[k] = '0;
      b_arr[k] = '0;
    end
    load_inputs(0, 0, 0, 0, 0, 0);
    for (int d = 0; d < ND; d++) begin
      last_mat[d] = '0;
      last_r[d]   = 0;
      last_c[d]   = 0;
    end

    repeat (3) tick();
    for (int d = 0; d < ND; d++) check_zero_outputs(d, $sformatf("reset_d%0d", d));
    reset_n = 1'b1;
    tick();

    // Scalar multiply, full matrix: mat_out[k] = 3k.
    for (int k = 0; k < N; k++) a_arr[k] = DW'(k);
    issue(0, "smul", 0, 3, 5, 5, 0, 0);
    collect(20);
    e0 = mat_out_v[0][24*DW +: DW];
    check("smul_e24", MW'(e0), MW'(72));

    // Multiply overflow: 200*3 wraps to 88, clamps to 511.
    a_arr[0] = 9'd200;
    issue(0, "mul_wrap", 0, 3, 5, 5, 0, 0);
    collect(20);
    e0 = mat_out_v[0][DW-1:0];
    check("mul_wrap_e0", MW'(e0), MW'(88));
    issue(1, "mul_sat", 0, 3, 5, 5, 0, 0);
    collect(20);
    e0 = mat_out_v[1][DW-1:0];
    check("mul_sat_e0", MW'(e0), MW'(511));

    // Subtract with borrow: 5-9 wraps to 508, clamps to 0.
    for (int k = 0; k < N; k++) begin
      a_arr[k] = 9'd5;
      b_arr[k] = 9'd9;
    end
    issue(0, "sub_wrap", 2, 0, 5, 5, 5, 5);
    collect(20);
    e0 = mat_out_v[0][DW-1:0];
    check("sub_wrap_e0", MW'(e0), MW'(508));
    issue(1, "sub_sat", 2, 0, 5, 5, 5, 5);
    collect(20);

    // Add on a 2x3 window; index 3 (row 0, col 3) must read 0.
    for (int k = 0; k < N; k++) begin
      a_arr[k] = 9'd10;
      b_arr[k] = 9'd10;
    end
    issue(0, "add_part", 1, 0, 2, 3, 2, 3);
    collect(20);
    e0 = mat_out_v[0][3*DW +: DW];
    check("add_part_e3", MW'(e0), '0);
    e0 = mat_out_v[0][7*DW +: DW];
    check("add_part_e7", MW'(e0), MW'(20));

    // Shape mismatch: rejected, previous result kept. A valid start held
    // during the FIN cycle must be ignored.
    issue(0, "dim_err", 1, 0, 3, 3, 3, 2);
    c_b        = 3'd3;
    start_v[0] = 1'b1;
    collect(10);
    start_v[0] = 1'b0;
    check("fin_start_busy",  MW'(busy_v[0]),  '0);
    check("fin_start_error", MW'(error_v[0]), MW'(1));
    tick();
    check("fin_start_idle",  MW'(busy_v[0]),  '0);

    // Dimension boundaries.
    issue(0, "r_big", 0, 1, 6, 5, 0, 0);
    collect(10);
    issue(0, "c_zero", 0, 1, 5, 0, 0, 0);
    collect(10);

    // Valid request after rejection clears error.
    for (int k = 0; k < N; k++) begin
      a_arr[k] = 9'd50;
      b_arr[k] = 9'd20;
    end
    issue(0, "err_clear", 2, 0, 3, 4, 3, 4);
    collect(20);

    // Abort: start re-pulsed into beat 1 is ignored, abort sampled at beat 2.
    for (int k = 0; k < N; k++) a_arr[k] = DW'(k + 1);
    load_inputs(0, 2, 5, 5, 0, 0);
    start_v[0] = 1'b1;
    tick();
    tick();
    start_v[0] = 1'b0;
    check("abort_busy_beat1", MW'(busy_v[0]), MW'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    last_mat[0] = '0;
    last_r[0]   = 0;
    last_c[0]   = 0;
    check("abort_busy",  MW'(busy_v[0]),  '0);
    check("abort_mat",   mat_out_v[0],    '0);
    check("abort_r_out", MW'(r_out_v[0]), '0);
    check("abort_c_out", MW'(c_out_v[0]), '0);
    check("abort_error", MW'(error_v[0]), '0);
    dones = 0;
    repeat (10) begin
      if (done_v[0]) dones++;
      tick();
    end
    check("abort_no_done", MW'(dones), '0);

    // Hadamard with LANES=4 (saturating) and LANES=1 (wrapping).
    for (int k = 0; k < N; k++) begin
      a_arr[k] = DW'($urandom_range(0, MAXV));
      b_arr[k] = DW'($urandom_range(0, 40));
    end
    issue(1, "had_l4", 3, 0, 5, 5, 5, 5);
    collect(30);
    issue(1, "had_l4_part", 3, 0, 4, 2, 4, 2);
    collect(30);
    issue(2, "had_l1", 3, 0, 5, 5, 5, 5);
    collect(40);

    // Asynchronous reset in the middle of a LANES=1 run.
    for (int k = 0; k < N; k++) begin
      a_arr[k] = DW'($urandom_range(1, MAXV));
      b_arr[k] = DW'($urandom_range(1, MAXV));
    end
    load_inputs(3, 0, 5, 5, 5, 5);
    start_v[2] = 1'b1;
    tick();
    start_v[2] = 1'b0;
    repeat (4) tick();
    check("mid_run_busy", MW'(busy_v[2]), MW'(1));
    #2 reset_n = 1'b0;
    #1;
    check_zero_outputs(2, "async_reset");
    tick();
    reset_n = 1'b1;
    tick();
    for (int d = 0; d < ND; d++) begin
      last_mat[d] = '0;
      last_r[d]   = 0;
      last_c[d]   = 0;
    end

    issue(2, "post_reset", 3, 0, 3, 5, 3, 5);
    collect(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
